// File: rtl/acc_ctrl.sv
// acc_ctrl: APB slave that sequences the matrix_multiply datapath.
// Software loads operands A and B, writes START, and reads the captured result C once
// DONE is set (or irq_o fires). The block waits LATENCY edges, then captures acc_out_i.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   paddr/pwdata/pwrite  APB request
//   psel/penable         APB select / enable (access phase = psel & penable)
//   prdata/pready        APB read data (combinational), always-ready
//   pslverr              APB error response, valid in the access phase only
//   irq_o                level interrupt, DONE & IRQ_EN
//   acc_in_A_o/B_o       operand buses to the datapath (copies of A/B registers)
//   acc_out_i            result from the datapath
module acc_ctrl #(
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  input  logic                      pwrite,
  input  logic                      psel,
  input  logic                      penable,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      irq_o,
  output logic [15:0][7:0]          acc_in_A_o,
  output logic [15:0][7:0]          acc_in_B_o,
  input  logic [15:0][15:0]         acc_out_i
);

  localparam int unsigned AW = APB_ADDR_WIDTH;
  localparam logic [AW-1:0] AddrCtrl   = AW'(32'h00);
  localparam logic [AW-1:0] AddrStatus = AW'(32'h04);
  localparam logic [AW-1:0] AddrA      = AW'(32'h10);
  localparam logic [AW-1:0] AddrB      = AW'(32'h20);
  localparam logic [AW-1:0] AddrC      = AW'(32'h40);
  localparam logic [7:0]    CntInit    = 8'(LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [127:0] a_q, a_d;
  logic [127:0] b_q, b_d;
  logic [255:0] c_q, c_d;
  logic         irq_en_q, irq_en_d;
  logic         done_q, done_d;

  logic access, wr, aligned, busy;
  logic hit_ctrl, hit_status, hit_a, hit_b, hit_c, mapped;

  assign access  = psel & penable;
  assign wr      = access & pwrite;
  assign aligned = (paddr[1:0] == 2'b00);
  assign busy    = (state_q == StRun);

  assign hit_ctrl   = (paddr == AddrCtrl);
  assign hit_status = (paddr == AddrStatus);
  assign hit_a      = aligned && ({paddr[AW-1:4], 4'h0} == AddrA);
  assign hit_b      = aligned && ({paddr[AW-1:4], 4'h0} == AddrB);
  assign hit_c      = aligned && ({paddr[AW-1:5], 5'h00} == AddrC);
  assign mapped     = hit_ctrl | hit_status | hit_a | hit_b | hit_c;

  assign pready     = 1'b1;
  assign irq_o      = done_q & irq_en_q;
  assign acc_in_A_o = a_q;
  assign acc_in_B_o = b_q;

  // Read data mux; driven only for reads in the access phase, zero otherwise.
  always_comb begin
    prdata = '0;
    if (access && !pwrite) begin
      if (hit_ctrl) begin
        prdata = {30'b0, irq_en_q, 1'b0};
      end else if (hit_status) begin
        prdata = {30'b0, done_q, busy};
      end else if (hit_a) begin
        prdata = a_q[{paddr[3:2], 5'b0} +: 32];
      end else if (hit_b) begin
        prdata = b_q[{paddr[3:2], 5'b0} +: 32];
      end else if (hit_c) begin
        prdata = c_q[{paddr[4:2], 5'b0} +: 32];
      end
    end
  end

  // Error response: unmapped access, writes blocked while running, writes to read-only bits.
  always_comb begin
    pslverr = 1'b0;
    if (access) begin
      if (!mapped) begin
        pslverr = 1'b1;
      end else if (pwrite) begin
        if (hit_ctrl && pwdata[0] && busy) pslverr = 1'b1;
        if ((hit_a || hit_b) && busy)      pslverr = 1'b1;
        if (hit_c)                         pslverr = 1'b1;
        if (hit_status && pwdata[0])       pslverr = 1'b1;
      end
    end
  end

  // Operand registers are frozen during RUN so the datapath sees stable inputs.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr && !busy) begin
      if (hit_a) a_d[{paddr[3:2], 5'b0} +: 32] = pwdata;
      if (hit_b) b_d[{paddr[3:2], 5'b0} +: 32] = pwdata;
    end
  end

  // Sequencer. Capture sets DONE after the W1C clear so a colliding clear loses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;

    if (wr && hit_ctrl)              irq_en_d = pwdata[1];
    if (wr && hit_status && pwdata[1]) done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr && hit_ctrl && pwdata[0]) begin
          cnt_d   = CntInit;
          done_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          c_d     = acc_out_i;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

endmodule
